// File: rtl/bus_arbiter16.sv
// bus_arbiter16: two-requester burst arbiter for a shared 16-bit path; define ARB_FAIR_EN for round-robin arbitration
module mux16 (
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        sel,
  output logic [15:0] out
);
  assign out = sel ? in_b : in_a;
endmodule

module bus_arbiter16 #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_b,
  output logic        sel,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state;
  logic [3:0] cnt;
  logic last_owner, xfer, last_beat, ten_end, pick_b, any;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer = out_valid & out_ready;
  assign last_beat = xfer & (cnt == 4'(MAX_BURST - 1));
  assign any = req_a | req_b;
  // IDLE re-arbitrates every cycle, so it is treated as a permanently ended tenure
  assign ten_end = state == OWN_A ? ~req_a | last_beat :
                   state == OWN_B ? ~req_b | last_beat : 1'b1;
`ifdef ARB_FAIR_EN
  assign pick_b = (req_a & req_b) ? ~last_owner : req_b;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign pick_b = req_b & ~req_a;
`endif
  mux16 u_mux (.in_a(data_a), .in_b(data_b), .sel(sel), .out(out));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      sel <= 1'b0;
      cnt <= '0;
      last_owner <= 1'b1;
    end else if (ten_end) begin
      cnt <= '0;
      state <= !any ? IDLE : pick_b ? OWN_B : OWN_A;
      gnt_a <= any & ~pick_b;
      gnt_b <= pick_b;
      if (any) begin
        sel <= pick_b;
        last_owner <= pick_b;
      end
    end else if (xfer) begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: doc/bus_arbiter16.md
BUS_ARBITER16 -- requirements
Module: bus_arbiter16

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 4, maximum beats per grant tenure (legal 1..16).
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port req_a, input, 1, requester A wants the shared 16-bit path.
REQ-005 Port data_a, input, 16, requester A word.
REQ-006 Port gnt_a, output, 1, registered grant to requester A.
REQ-007 Port req_b, input, 1, requester B wants the shared 16-bit path.
REQ-008 Port data_b, input, 16, requester B word.
REQ-009 Port gnt_b, output, 1, registered grant to requester B.
REQ-010 Port sel, output, 1, Mux16 select driven by the block (0 = in_a/data_a, 1 = in_b/data_b).
REQ-011 Port out, output, 16, shared path word, produced by an internal Mux16 instance (in_a=data_a, in_b=data_b, sel=sel).
REQ-012 Port out_valid, output, 1, out carries a valid beat.
REQ-013 Port out_ready, input, 1, consumer accepts the beat.

Function
REQ-014 The FSM SHALL have states IDLE, OWN_A and OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B, at most one grant high.
REQ-015 out_valid SHALL equal (gnt_a & req_a) | (gnt_b & req_b), combinationally.
REQ-016 A transfer occurs in a cycle where out_valid=1 and out_ready=1.
REQ-017 A 4-bit beat counter SHALL increment on each transfer and clear on every grant change or entry to IDLE.
REQ-018 From IDLE with a request sampled at edge N, the grant SHALL be high after edge N (one-cycle grant latency).
REQ-019 IDLE with one requester SHALL grant that requester.
REQ-020 IDLE with both requesting SHALL grant per the arbitration policy (REQ-030/031).
REQ-021 Tenure ends when the owner's req is low while granted, or on the transfer that is the MAX_BURST-th beat.
REQ-022 At tenure end with the other requester's req high, the FSM SHALL switch directly to the other owner with no IDLE bubble.
REQ-023 At tenure end by burst limit with only the owner requesting, the FSM SHALL keep the same owner and clear the counter.
REQ-024 At tenure end with no request pending, the FSM SHALL go to IDLE.
REQ-025 sel SHALL change only on a grant change and SHALL hold its last value in IDLE.
REQ-026 The grant SHALL never change while out_valid=1 and out_ready=0 (stall).
REQ-027 Requesters SHALL hold req and data stable while granted and stalled; the bench checks this as an environment assertion.
REQ-028 A last_owner register SHALL record the most recent owner, updated on each grant assertion.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state IDLE, gnt_a=0, gnt_b=0, sel=0, counter=0, last_owner=B, and therefore out_valid=0, including mid-burst; first arbitration occurs at the first edge after release.

Configuration
REQ-030 With ARB_FAIR_EN defined, both-requesting decisions (in IDLE and at tenure end) SHALL grant the requester that is not last_owner (round-robin).
REQ-031 Without ARB_FAIR_EN, both-requesting decisions SHALL always grant A (fixed priority); at burst-limit end with both requesting, A retains or takes the grant.

Verification
REQ-032 Reset, then req_a=1 with data_a=0x1234 and out_ready=1 -> gnt_a=1 one cycle later, sel=0, out=0x1234, out_valid=1, exactly 4 beats, then re-grant to A with counter cleared.
REQ-033 ARB_FAIR_EN, both req high continuously, out_ready=1, MAX_BURST=4 -> grants alternate A,A,A,A,B,B,B,B,A..., with no idle cycle between tenures.
REQ-034 Owner A, out_ready=0 for 5 cycles with req_b=1 -> gnt_a, sel and out held stable for 5 cycles, and the counter does not advance.
REQ-035 Owner B drops req_b after 2 beats while req_a=1 -> gnt_a=1 on the next edge, sel=0, and out_valid=1 immediately.
REQ-036 rst_n low mid-burst in OWN_B -> gnt_b=0, sel=0 and out_valid=0 without a clock edge; with both req high after release, A is granted first.
REQ-037 ARB_FAIR_EN undefined, both req high, out_ready=1 -> gnt_a=1 permanently and gnt_b never asserts.
